mcu1_core: RTL and testbench

Multi-cycle accumulator microcontroller core, the parametrised successor of the single-cycle `mcu` datapath. It fetches and executes instructions over an external req/ack memory port, so it can sit in front of memories with wait states. It extends the instruction set with SUB/AND/OR/XOR/LDI, conditional branches on N and Z, and HALT. It is the top-level CPU instance under the test `main` and under future SoC wrappers.

---
 rtl/mcu1_core_if.sv | 32 +++
 rtl/mcu1_core.sv | 227 ++++++++++++++++++++++
 tb/tb_mcu1_core.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu1_core_if.sv
// mcu1_core_if: word-addressed req/ack memory port of the mcu1_core CPU.
// The core drives the request side (master); a memory or bus bridge
// answers with read data and a completion ack (slave).
interface mcu1_core_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mcu1_core.sv
// mcu1_core: multi-cycle accumulator CPU with a req/ack memory port.
// Every instruction is fetched over the port, decoded, and (for memory
// operands) followed by one data transaction. Request outputs are
// registered and held stable until the memory acks.
// Optional feature: define MCU1_MUL_EN to make opcode E a MUL through the
// memory-read path; otherwise opcode E behaves as NOP and no multiplier
// exists.
module mcu1_core #(
    parameter int            AW       = 12,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    mcu1_core_if.master   mem,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic [1:0]    flags
);

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_JEQ  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_JLT  = 4'hA;
    localparam logic [3:0] OP_JNE  = 4'hB;
    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEMRD,
        S_MEMWR,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          n_q, n_d;
    logic          z_q, z_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          halted_q, halted_d;

    logic [3:0]    op;
    logic [AW-1:0] c_field;
    logic [DW-1:0] ldi_val;
    logic [DW-1:0] alu_res;
    logic          alu_wr_a;

    assign op      = ir_q[DW-1:DW-4];
    assign c_field = ir_q[AW-1:0];
    assign ldi_val = {{(DW-AW){1'b0}}, c_field};

    // ALU: result of a memory-operand op; CMP only produces flags
    always_comb begin
        alu_res  = mem.mem_rdata;
        alu_wr_a = 1'b1;
        case (op)
            OP_ADD: alu_res = acc_q + mem.mem_rdata;
            OP_SUB: alu_res = acc_q - mem.mem_rdata;
            OP_AND: alu_res = acc_q & mem.mem_rdata;
            OP_OR:  alu_res = acc_q | mem.mem_rdata;
            OP_XOR: alu_res = acc_q ^ mem.mem_rdata;
            OP_CMP: alu_wr_a = 1'b0;
`ifdef MCU1_MUL_EN
            OP_MUL: alu_res = acc_q * mem.mem_rdata;
`endif
            default: alu_res = mem.mem_rdata;
        endcase
    end

    // Next-state logic: FSM sequencing, register updates and bus requests
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        n_d      = n_q;
        z_d      = z_q;
        ir_d     = ir_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        halted_d = halted_q;

        case (state_q)
            S_FETCH: begin
                // First cycle in a request state raises the request;
                // it then stays unchanged until ack.
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end else if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_FETCH;
                case (op)
                    OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP:
                        state_d = S_MEMRD;
`ifdef MCU1_MUL_EN
                    OP_MUL:
                        state_d = S_MEMRD;
`endif
                    OP_ST:
                        state_d = S_MEMWR;
                    OP_JMP:
                        pc_d = c_field;
                    OP_JEQ:
                        if (z_q) pc_d = c_field;
                    OP_JLT:
                        if (n_q) pc_d = c_field;
                    OP_JNE:
                        if (!z_q) pc_d = c_field;
                    OP_LDI: begin
                        acc_d = ldi_val;
                        n_d   = ldi_val[DW-1];
                        z_d   = (ldi_val == '0);
                    end
                    OP_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEMRD: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = c_field;
                end else if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_FETCH;
                    if (alu_wr_a) begin
                        acc_d = alu_res;
                        n_d   = alu_res[DW-1];
                        z_d   = (alu_res == '0);
                    end else begin
                        n_d = (acc_q < mem.mem_rdata);
                        z_d = (acc_q == mem.mem_rdata);
                    end
                end
            end

            S_MEMWR: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = c_field;
                    wdata_d = acc_q;
                end else if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                req_d    = 1'b0;
                halted_d = 1'b1;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // State register; async reset also abandons any outstanding request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            acc_q    <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            ir_q     <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            n_q      <= n_d;
            z_q      <= z_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign halted        = halted_q;
    assign pc            = pc_q;
    assign acc           = acc_q;
    assign flags         = {n_q, z_q};

endmodule

// File: tb/tb_mcu1_core.sv
// tb_mcu1_core: directed programs with hand-computed results for mcu1_core.
// A behavioural word memory answers requests with a programmable number of
// wait states and logs reads, writes and request-stability violations.
module tb_mcu1_core;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        halted;
    logic [11:0] pc;
    logic [15:0] acc;
    logic [1:0]  flags;

    mcu1_core_if #(.AW(12), .DW(16)) mem_if ();

    mcu1_core #(.AW(12), .DW(16), .RESET_PC(12'h000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .mem     (mem_if),
        .halted  (halted),
        .pc      (pc),
        .acc     (acc),
        .flags   (flags)
    );

    always #5 clock = ~clock;

    // Program memory, written only by the stimulus process
    logic [15:0] mem_arr [0:4095];
    int          ws = 0;

    // Logged by the memory model only
    int          rd_cnt, wr_cnt, stab_err, wait_cnt;
    logic [11:0] last_wa;
    logic [15:0] last_wd;
    logic [11:0] hold_addr;
    logic        hold_we;
    logic [15:0] hold_wd;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: evaluates on the falling edge so ack/rdata are stable
    // at the rising edge where the core samples them.
    always @(negedge clock) begin
        if (!reset_n) begin
            rd_cnt   = 0;
            wr_cnt   = 0;
            stab_err = 0;
            wait_cnt = 0;
            last_wa  = '0;
            last_wd  = '0;
            mem_if.mem_ack   = 1'b0;
            mem_if.mem_rdata = '0;
        end else if (mem_if.mem_req) begin
            if (wait_cnt == 0) begin
                hold_addr = mem_if.mem_addr;
                hold_we   = mem_if.mem_we;
                hold_wd   = mem_if.mem_wdata;
            end else if (mem_if.mem_addr !== hold_addr || mem_if.mem_we !== hold_we ||
                         mem_if.mem_wdata !== hold_wd) begin
                stab_err++;
            end
            if (wait_cnt == ws) begin
                mem_if.mem_ack = 1'b1;
                if (mem_if.mem_we) begin
                    wr_cnt++;
                    last_wa = mem_if.mem_addr;
                    last_wd = mem_if.mem_wdata;
                end else begin
                    rd_cnt++;
                    mem_if.mem_rdata = mem_arr[mem_if.mem_addr];
                end
                wait_cnt = 0;
            end else begin
                mem_if.mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_if.mem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] c);
        return {op, c};
    endfunction

    // Hold the core in reset and clear memory before loading a program
    task automatic clear_mem(input int wait_states);
        reset_n = 1'b0;
        ws = wait_states;
        for (int i = 0; i < 4096; i++) mem_arr[i] = 16'hF000;
    endtask

    task automatic start();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_to_halt(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        if (!halted) check({tag, "_timeout"}, 32'(cyc), 32'(budget + 1));
    endtask

    initial begin
        int cyc;
        int wcount;

        // Reset values and the first request
        clear_mem(0);
        mem_arr[0] = ins(4'hC, 12'h005);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req",    32'(mem_if.mem_req),   32'h0);
        check("rst_we",     32'(mem_if.mem_we),    32'h0);
        check("rst_addr",   32'(mem_if.mem_addr),  32'h0);
        check("rst_wdata",  32'(mem_if.mem_wdata), 32'h0);
        check("rst_halted", 32'(halted),           32'h0);
        check("rst_pc",     32'(pc),               32'h0);
        check("rst_acc",    32'(acc),              32'h0);
        check("rst_flags",  32'(flags),            32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("first_req",  32'(mem_if.mem_req),  32'h1);
        check("first_addr", 32'(mem_if.mem_addr), 32'h0);
        check("first_we",   32'(mem_if.mem_we),   32'h0);

        // LDI 5; ADD [0x10]; ST [0x11]; HALT  with M[0x10]=3, no wait states
        clear_mem(0);
        mem_arr[0] = ins(4'hC, 12'h005);
        mem_arr[1] = ins(4'h1, 12'h010);
        mem_arr[2] = ins(4'h3, 12'h011);
        mem_arr[3] = ins(4'hF, 12'h000);
        mem_arr[16'h10] = 16'd3;
        start();
        run_to_halt("add_st", 200, cyc);
        check("add_st_cycles", 32'(cyc),     32'd16);
        check("add_st_wcnt",   32'(wr_cnt),  32'd1);
        check("add_st_waddr",  32'(last_wa), 32'h011);
        check("add_st_wdata",  32'(last_wd), 32'h0008);
        check("add_st_halted", 32'(halted),  32'h1);
        check("add_st_acc",    32'(acc),     32'h0008);
        check("add_st_flags",  32'(flags),   32'h0);
        check("add_st_pc",     32'(pc),      32'h004);
        repeat (3) @(posedge clock);
        #1;
        check("halt_no_req",   32'(mem_if.mem_req), 32'h0);

        // LDI 2; CMP [0x10]=7; JLT 5  -> taken, N=1 Z=0
        clear_mem(0);
        mem_arr[0] = ins(4'hC, 12'h002);
        mem_arr[1] = ins(4'h4, 12'h010);
        mem_arr[2] = ins(4'hA, 12'h005);
        mem_arr[3] = ins(4'hC, 12'h0AA);
        mem_arr[5] = ins(4'hF, 12'h000);
        mem_arr[16'h10] = 16'd7;
        start();
        run_to_halt("jlt", 200, cyc);
        check("jlt_flags", 32'(flags), 32'h2);
        check("jlt_acc",   32'(acc),   32'h0002);
        check("jlt_pc",    32'(pc),    32'h006);

        // LDI 2; CMP [0x10]=2; JEQ 5  -> taken, N=0 Z=1
        clear_mem(0);
        mem_arr[0] = ins(4'hC, 12'h002);
        mem_arr[1] = ins(4'h4, 12'h010);
        mem_arr[2] = ins(4'h5, 12'h005);
        mem_arr[3] = ins(4'hC, 12'h0AA);
        mem_arr[5] = ins(4'hF, 12'h000);
        mem_arr[16'h10] = 16'd2;
        start();
        run_to_halt("jeq", 200, cyc);
        check("jeq_flags", 32'(flags), 32'h1);
        check("jeq_acc",   32'(acc),   32'h0002);
        check("jeq_pc",    32'(pc),    32'h006);

        // LDI 1; SUB [0x10]=1; JNE 5 not taken -> falls through to ST [0x12]
        clear_mem(0);
        mem_arr[0] = ins(4'hC, 12'h001);
        mem_arr[1] = ins(4'h6, 12'h010);
        mem_arr[2] = ins(4'hB, 12'h005);
        mem_arr[3] = ins(4'h3, 12'h012);
        mem_arr[4] = ins(4'hF, 12'h000);
        mem_arr[5] = ins(4'hC, 12'h055);
        mem_arr[6] = ins(4'hF, 12'h000);
        mem_arr[16'h10] = 16'd1;
        start();
        run_to_halt("jne", 200, cyc);
        check("jne_acc",   32'(acc),     32'h0000);
        check("jne_flags", 32'(flags),   32'h1);
        check("jne_pc",    32'(pc),      32'h005);
        check("jne_waddr", 32'(last_wa), 32'h012);
        check("jne_wcnt",  32'(wr_cnt),  32'd1);

        // LDI 0; SUB [0x10]=1 -> wraps to 0xFFFF, N=1
        clear_mem(0);
        mem_arr[0] = ins(4'hC, 12'h000);
        mem_arr[1] = ins(4'h6, 12'h010);
        mem_arr[2] = ins(4'hF, 12'h000);
        mem_arr[16'h10] = 16'd1;
        start();
        run_to_halt("wrap", 200, cyc);
        check("wrap_acc",   32'(acc),   32'hFFFF);
        check("wrap_flags", 32'(flags), 32'h2);

        // Same ADD/ST program with 3 wait states: 6 transactions x 3 extra cycles
        clear_mem(3);
        mem_arr[0] = ins(4'hC, 12'h005);
        mem_arr[1] = ins(4'h1, 12'h010);
        mem_arr[2] = ins(4'h3, 12'h011);
        mem_arr[3] = ins(4'hF, 12'h000);
        mem_arr[16'h10] = 16'd3;
        start();
        run_to_halt("ws3", 400, cyc);
        check("ws3_cycles", 32'(cyc),      32'd34);
        check("ws3_stable", 32'(stab_err), 32'd0);
        check("ws3_acc",    32'(acc),      32'h0008);
        check("ws3_wdata",  32'(last_wd),  32'h0008);

        // Reset asserted while the ADD operand read is waiting
        clear_mem(3);
        mem_arr[0] = ins(4'hC, 12'h005);
        mem_arr[1] = ins(4'h1, 12'h010);
        mem_arr[2] = ins(4'hF, 12'h000);
        mem_arr[16'h10] = 16'd3;
        start();
        wcount = 0;
        while (!(mem_if.mem_req && !mem_if.mem_we && mem_if.mem_addr == 12'h010) && wcount < 100) begin
            @(negedge clock);
            wcount++;
        end
        check("midrd_reached", 32'(wcount < 100), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrd_req_drop", 32'(mem_if.mem_req), 32'h0);
        check("midrd_pc",       32'(pc),              32'h000);
        check("midrd_acc",      32'(acc),             32'h0000);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("midrd_refetch_req",  32'(mem_if.mem_req),  32'h1);
        check("midrd_refetch_addr", 32'(mem_if.mem_addr), 32'h000);

        // Opcode E with A=3, M[0x20]=4
        clear_mem(0);
        mem_arr[0] = ins(4'hC, 12'h003);
        mem_arr[1] = ins(4'hE, 12'h020);
        mem_arr[2] = ins(4'hF, 12'h000);
        mem_arr[16'h20] = 16'd4;
        start();
        run_to_halt("op_e", 200, cyc);
`ifdef MCU1_MUL_EN
        check("mul_acc",   32'(acc),    32'h000C);
        check("mul_reads", 32'(rd_cnt), 32'd4);
`else
        check("nop_e_acc",   32'(acc),    32'h0003);
        check("nop_e_reads", 32'(rd_cnt), 32'd3);
        check("nop_e_cycles", 32'(cyc),   32'd9);
`endif
        check("op_e_flags", 32'(flags), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
